// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall-vector merge, trap/mret flush sequencing and fetch redirect.
// Optional perf counters (stall_cycles_o, flush_events_o) enabled by PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        n_rst_i,
   input  logic        stall_req_if_i,
   input  logic        stall_req_id_i,
   input  logic        stall_req_ex_i,
   input  logic        stall_req_mem_i,
   input  logic        mem_busy_i,
   input  logic [31:0] exception_i,
   input  logic        mret_i,
   input  logic        branch_redirect_i,
   input  logic [31:0] branch_pc_i,
   input  logic [31:0] trap_vector_i,
   input  logic [31:0] mepc_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        trap_taken_o,
   output logic [31:0] trap_cause_o,
   output logic        mret_taken_o
`ifdef PIPE_CTRL_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles_o,
   output logic [31:0] flush_events_o
`endif
);

   typedef enum logic [1:0] {IDLE, TRAP_WAIT, FLUSH} state_t;

   localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        is_trap_q, is_trap_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] target_q, target_d;
   logic        flush_q, flush_d;
   logic        redirect_q, redirect_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        trap_taken_q, trap_taken_d;
   logic [31:0] trap_cause_q, trap_cause_d;
   logic        mret_taken_q, mret_taken_d;
   logic        go_flush;

   // mtvec low bits are mode bits, never part of the vector address
   logic unused_tvec_mode;
   assign unused_tvec_mode = ^trap_vector_i[1:0];

   // Held stages are a prefix from PC up to the highest requester; nothing is held while sequencing
   always_comb begin
      stall_o = 6'b000000;
      if (n_rst_i && state_q == IDLE) begin
         if (stall_req_mem_i)     stall_o = 6'b011111;
         else if (stall_req_ex_i) stall_o = 6'b001111;
         else if (stall_req_id_i) stall_o = 6'b000111;
         else if (stall_req_if_i) stall_o = 6'b000011;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      is_trap_d     = is_trap_q;
      cause_d       = cause_q;
      target_d      = target_q;
      flush_d       = 1'b0;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      trap_taken_d  = 1'b0;
      trap_cause_d  = trap_cause_q;
      mret_taken_d  = 1'b0;
      go_flush      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (exception_i != 32'd0 || mret_i) begin
               is_trap_d = (exception_i != 32'd0);
               cause_d   = exception_i;
               target_d  = (exception_i != 32'd0) ? {trap_vector_i[31:2], 2'b00} : mepc_i;
               if (mem_busy_i) state_d = TRAP_WAIT;
               else            go_flush = 1'b1;
            end else if (branch_redirect_i && !stall_req_ex_i && !stall_req_mem_i) begin
               redirect_d    = 1'b1;
               redirect_pc_d = branch_pc_i;
            end
         end
         TRAP_WAIT: begin
            if (!mem_busy_i) go_flush = 1'b1;
         end
         FLUSH: begin
            if (cnt_q == 3'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q - 3'd1;
               flush_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // First flush cycle carries the redirect and the CSR handshake pulse
      if (go_flush) begin
         state_d       = FLUSH;
         cnt_d         = CNT_INIT;
         flush_d       = 1'b1;
         redirect_d    = 1'b1;
         redirect_pc_d = target_d;
         trap_taken_d  = is_trap_d;
         mret_taken_d  = !is_trap_d;
         if (is_trap_d) trap_cause_d = cause_d;
      end
   end

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state_q       <= IDLE;
         cnt_q         <= 3'd0;
         is_trap_q     <= 1'b0;
         cause_q       <= 32'd0;
         target_q      <= 32'd0;
         flush_q       <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= RESET_PC;
         trap_taken_q  <= 1'b0;
         trap_cause_q  <= 32'd0;
         mret_taken_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         is_trap_q     <= is_trap_d;
         cause_q       <= cause_d;
         target_q      <= target_d;
         flush_q       <= flush_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         trap_taken_q  <= trap_taken_d;
         trap_cause_q  <= trap_cause_d;
         mret_taken_q  <= mret_taken_d;
      end
   end

   assign flush_o       = flush_q;
   assign redirect_o    = redirect_q;
   assign redirect_pc_o = redirect_pc_q;
   assign trap_taken_o  = trap_taken_q;
   assign trap_cause_o  = trap_cause_q;
   assign mret_taken_o  = mret_taken_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (stall_o != 6'b000000) stall_cycles_d = stall_cycles_q + 32'd1;
      if (go_flush)             flush_events_d = flush_events_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         stall_cycles_q <= 32'd0;
         flush_events_q <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_events_o = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: stall table, directed trap/mret/branch/reset sequences,
// and random traffic compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

   localparam int unsigned FC  = 4;
   localparam logic [31:0] RPC = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        req_if = 0, req_id = 0, req_ex = 0, req_mem = 0, busy = 0;
   logic [31:0] exc = 0;
   logic        mret = 0, br = 0;
   logic [31:0] br_pc = 0, tvec = 0, mepc = 0;
   logic [5:0]  stall_o;
   logic        flush_o, redirect_o, trap_taken_o, mret_taken_o;
   logic [31:0] redirect_pc_o, trap_cause_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] stall_cycles_o, flush_events_o;
`endif

   pipe_ctrl #(.FLUSH_CYCLES(FC), .RESET_PC(RPC)) dut (
      .clk_i(clk), .n_rst_i(n_rst),
      .stall_req_if_i(req_if), .stall_req_id_i(req_id),
      .stall_req_ex_i(req_ex), .stall_req_mem_i(req_mem),
      .mem_busy_i(busy), .exception_i(exc), .mret_i(mret),
      .branch_redirect_i(br), .branch_pc_i(br_pc),
      .trap_vector_i(tvec), .mepc_i(mepc),
      .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
      .redirect_pc_o(redirect_pc_o), .trap_taken_o(trap_taken_o),
      .trap_cause_o(trap_cause_o), .mret_taken_o(mret_taken_o)
`ifdef PIPE_CTRL_PERF_CNT_EN
      , .stall_cycles_o(stall_cycles_o), .flush_events_o(flush_events_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: remaining flush cycles, waiting-for-bus flag, latched event, expected registered outputs
   int          m_flush_left;
   bit          m_wait;
   bit          m_trap;
   logic [31:0] m_cause, m_target;
   logic        e_flush, e_redirect, e_tt, e_mt;
   logic [31:0] e_pc, e_cause;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_flush_left = 0; m_wait = 0; m_trap = 0; m_cause = 0; m_target = 0;
      e_flush = 0; e_redirect = 0; e_tt = 0; e_mt = 0; e_pc = RPC; e_cause = 0;
   endtask

   function automatic logic [5:0] exp_stall();
      if (!n_rst || m_wait || m_flush_left > 0) return 6'd0;
      if (req_mem) return 6'b011111;
      if (req_ex)  return 6'b001111;
      if (req_id)  return 6'b000111;
      if (req_if)  return 6'b000011;
      return 6'd0;
   endfunction

   task automatic start_flush();
      m_wait = 0;
      m_flush_left = FC;
      e_flush = 1;
      e_redirect = 1;
      e_pc = m_target;
      if (m_trap) begin e_tt = 1; e_cause = m_cause; end
      else e_mt = 1;
   endtask

   task automatic model_edge();
      e_redirect = 0; e_tt = 0; e_mt = 0;
      if (m_flush_left > 0) begin
         m_flush_left--;
         e_flush = (m_flush_left > 0);
      end else if (m_wait) begin
         if (!busy) start_flush();
      end else if (exc != 0 || mret) begin
         m_trap   = (exc != 0);
         m_cause  = exc;
         m_target = m_trap ? (tvec & 32'hFFFF_FFFC) : mepc;
         if (busy) m_wait = 1;
         else start_flush();
      end else if (br && !req_ex && !req_mem) begin
         e_redirect = 1;
         e_pc = br_pc;
      end
   endtask

   task automatic check_regs();
      chk("flush_o", flush_o, e_flush);
      chk("redirect_o", redirect_o, e_redirect);
      chk("redirect_pc_o", redirect_pc_o, e_pc);
      chk("trap_taken_o", trap_taken_o, e_tt);
      chk("trap_cause_o", trap_cause_o, e_cause);
      chk("mret_taken_o", mret_taken_o, e_mt);
   endtask

   // One clock: check combinational stall, advance model at the edge, check registered outputs
   task automatic cycle();
      #1;
      chk("stall_o", stall_o, exp_stall());
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
   endtask

   task automatic quiet();
      req_if = 0; req_id = 0; req_ex = 0; req_mem = 0; busy = 0;
      exc = 0; mret = 0; br = 0;
   endtask

   typedef struct {
      logic [3:0] req;   // {mem, ex, id, if}
      logic [5:0] exp;
   } stall_vec_t;

   stall_vec_t vecs[8];

   initial begin
      vecs[0] = '{4'b1010, 6'b011111};
      vecs[1] = '{4'b0010, 6'b000111};
      vecs[2] = '{4'b0100, 6'b001111};
      vecs[3] = '{4'b0001, 6'b000011};
      vecs[4] = '{4'b0000, 6'b000000};
      vecs[5] = '{4'b1111, 6'b011111};
      vecs[6] = '{4'b0110, 6'b001111};
      vecs[7] = '{4'b0011, 6'b000111};

      // Reset held with requests and an exception active
      model_reset();
      req_if = 1; req_id = 1; req_ex = 1; req_mem = 1; exc = 32'h3; mret = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", stall_o, 6'd0);
      chk("rst_flush", flush_o, 1'b0);
      chk("rst_redirect", redirect_o, 1'b0);
      chk("rst_pc", redirect_pc_o, RPC);
      chk("rst_trap_taken", trap_taken_o, 1'b0);
      quiet();
      @(negedge clk);
      n_rst = 1;
      $display("reset released");

      // Stall priority table
      foreach (vecs[i]) begin
         {req_mem, req_ex, req_id, req_if} = vecs[i].req;
         #1;
         chk("stall_table", stall_o, vecs[i].exp);
         $display("stall vec %0d req=%b stall=%b", i, vecs[i].req, stall_o);
         cycle();
      end
      quiet();

      // Trap held off by a bus transaction for 3 cycles
      exc = 32'h2; busy = 1; tvec = 32'h8000_0103;
      cycle();
      exc = 0;
      repeat (2) begin
         cycle();
         chk("trapwait_noflush", flush_o, 1'b0);
      end
      busy = 0;
      cycle();
      chk("trap_flush", flush_o, 1'b1);
      chk("trap_redirect", redirect_o, 1'b1);
      chk("trap_pc", redirect_pc_o, 32'h8000_0100);
      chk("trap_cause", trap_cause_o, 32'h2);
      chk("trap_taken", trap_taken_o, 1'b1);
      repeat (FC - 1) begin
         cycle();
         chk("trap_flush_hold", flush_o, 1'b1);
         chk("trap_redirect_once", redirect_o, 1'b0);
      end
      cycle();
      chk("trap_flush_end", flush_o, 1'b0);
      $display("trap sequence done");

      // mret without bus wait
      mret = 1; mepc = 32'h0000_1234;
      cycle();
      mret = 0;
      chk("mret_pc", redirect_pc_o, 32'h0000_1234);
      chk("mret_taken", mret_taken_o, 1'b1);
      chk("mret_flush", flush_o, 1'b1);
      repeat (FC) cycle();
      $display("mret sequence done");

      // Branch blocked by EX stall, then accepted
      br = 1; br_pc = 32'h40; req_ex = 1;
      cycle();
      chk("br_stalled", redirect_o, 1'b0);
      req_ex = 0;
      cycle();
      br = 0;
      chk("br_redirect", redirect_o, 1'b1);
      chk("br_pc", redirect_pc_o, 32'h40);
      chk("br_noflush", flush_o, 1'b0);
      cycle();

      // Branch and trap together: trap wins
      br = 1; br_pc = 32'h80; exc = 32'h5; tvec = 32'h0000_0200;
      cycle();
      br = 0; exc = 0;
      chk("brtrap_pc", redirect_pc_o, 32'h0000_0200);
      chk("brtrap_taken", trap_taken_o, 1'b1);
      repeat (FC) cycle();
      $display("branch sequences done");

      // Reset in the second flush cycle
      mret = 1; mepc = 32'h0000_0abc;
      cycle();
      mret = 0;
      cycle();
      chk("midflush_pre", flush_o, 1'b1);
      #2;
      n_rst = 0;
      #1;
      model_reset();
      chk("midflush_drop", flush_o, 1'b0);
      chk("midflush_pc", redirect_pc_o, RPC);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1;
      repeat (FC + 2) begin
         cycle();
         chk("post_rst_noflush", flush_o, 1'b0);
         chk("post_rst_noredir", redirect_o, 1'b0);
      end
      $display("reset mid-flush done");

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         req_if  = ($urandom_range(3) == 0);
         req_id  = ($urandom_range(3) == 0);
         req_ex  = ($urandom_range(4) == 0);
         req_mem = ($urandom_range(4) == 0);
         busy    = ($urandom_range(2) == 0);
         exc     = ($urandom_range(9) == 0) ? 32'($urandom_range(15, 1)) : 32'd0;
         mret    = ($urandom_range(11) == 0);
         br      = ($urandom_range(3) == 0);
         br_pc   = $urandom;
         tvec    = $urandom;
         mepc    = $urandom;
         cycle();
      end
      quiet();
      $display("random phase done");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
